// File: rtl/cp0_except_ctrl.sv
// CP0 exception controller: exception entry/return, MTC0/MFC0 access, interrupts.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_except_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    input  logic [5:0]  int_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic        timer_int_o
);

    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_ERET = 32'he;
    localparam logic [31:0] EXC_VEC  = 32'hBFC00380;
    localparam logic [31:0] PRID     = 32'h00004220;
    localparam logic [31:0] ST_RST   = 32'h00400000;
    localparam logic [31:0] ST_MASK  = 32'h0000FF03;

    localparam logic [4:0] A_BADV = 5'd8;
    localparam logic [4:0] A_CNT  = 5'd9;
    localparam logic [4:0] A_CMP  = 5'd11;
    localparam logic [4:0] A_ST   = 5'd12;
    localparam logic [4:0] A_CAU  = 5'd13;
    localparam logic [4:0] A_EPC  = 5'd14;
    localparam logic [4:0] A_PRID = 5'd15;

    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_timer_int;
    logic        w_eret;
    logic        w_exc;
    logic        w_mtc0;
    logic        w_exl;
    logic [4:0]  w_exccode;

    assign flush_o   = (excepttype_i != 32'h0);
    assign w_eret    = (excepttype_i == EXC_ERET);
    assign w_exc     = flush_o && !w_eret;
    // Any exception or ERET in flight swallows a same-cycle MTC0
    assign w_mtc0    = we_i && !flush_o;
    assign w_exl     = r_status[1];
    assign w_exccode = (excepttype_i == EXC_INT) ? 5'd0 : excepttype_i[4:0];

    assign newpc_o = w_eret ? r_epc : (flush_o ? EXC_VEC : 32'h0);

`ifdef CP0_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_int;
    logic        r_tick;

    // Count runs at half clock rate; Compare write clears a pending tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= 32'h0;
            r_compare   <= 32'h0;
            r_timer_int <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
            if (w_mtc0 && waddr_i == A_CNT)
                r_count <= wdata_i;
            else if (r_tick)
                r_count <= r_count + 32'd1;
            if (w_mtc0 && waddr_i == A_CMP) begin
                r_compare   <= wdata_i;
                r_timer_int <= 1'b0;
            end else if (r_compare != 32'h0 && r_count == r_compare) begin
                r_timer_int <= 1'b1;
            end
        end
    end

    assign w_count     = r_count;
    assign w_compare   = r_compare;
    assign w_timer_int = r_timer_int;
`else
    assign w_count     = 32'h0;
    assign w_compare   = 32'h0;
    assign w_timer_int = 1'b0;
`endif

    assign timer_int_o = w_timer_int;

    // Status: EXL set on entry, cleared on ERET, partial MTC0 writes
    always_ff @(posedge clk) begin
        if (rst)
            r_status <= ST_RST;
        else if (w_exc)
            r_status[1] <= 1'b1;
        else if (w_eret)
            r_status[1] <= 1'b0;
        else if (w_mtc0 && waddr_i == A_ST)
            r_status <= (r_status & ~ST_MASK) | (wdata_i & ST_MASK);
    end

    // Cause: sample interrupt lines, record ExcCode/BD, software IP bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cause <= 32'h0;
        end else begin
            r_cause[15:10] <= {int_i[5] | w_timer_int, int_i[4:0]};
            if (w_exc) begin
                r_cause[6:2] <= w_exccode;
                if (!w_exl)
                    r_cause[31] <= in_delayslot_i;
            end else if (w_mtc0 && waddr_i == A_CAU) begin
                r_cause[9:8] <= wdata_i[9:8];
            end
        end
    end

    // EPC: restart address on first-level entry, else MTC0
    always_ff @(posedge clk) begin
        if (rst)
            r_epc <= 32'h0;
        else if (w_exc && !w_exl)
            r_epc <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
        else if (w_mtc0 && waddr_i == A_EPC)
            r_epc <= wdata_i;
    end

    // BadVAddr: captured on address errors only
    always_ff @(posedge clk) begin
        if (rst)
            r_badvaddr <= 32'h0;
        else if (excepttype_i == EXC_ADEL || excepttype_i == EXC_ADES)
            r_badvaddr <= bad_addr_i;
    end

    assign status_o = r_status;
    assign cause_o  = {r_cause[31], w_timer_int, r_cause[29:0]};
    assign epc_o    = r_epc;

    // MFC0 read mux; unimplemented addresses read as zero
    always_comb begin
        rdata_o = 32'h0;
        case (raddr_i)
            A_BADV:  rdata_o = r_badvaddr;
            A_CNT:   rdata_o = w_count;
            A_CMP:   rdata_o = w_compare;
            A_ST:    rdata_o = r_status;
            A_CAU:   rdata_o = cause_o;
            A_EPC:   rdata_o = r_epc;
            A_PRID:  rdata_o = PRID;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Directed testbench for cp0_except_ctrl.
// Table of single-cycle vectors plus hand-written reset/interrupt/timer sequences.
module tb_cp0_except_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [5:0]  int_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        flush_o;
    logic [31:0] newpc_o;
    logic        timer_int_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cp0_except_ctrl dut (
        .clk(clk), .rst(rst),
        .excepttype_i(excepttype_i), .pc_i(pc_i),
        .in_delayslot_i(in_delayslot_i), .bad_addr_i(bad_addr_i),
        .int_i(int_i), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(rdata_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
        .flush_o(flush_o), .newpc_o(newpc_o), .timer_int_o(timer_int_o)
    );

    typedef struct {
        logic [31:0] exc;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [31:0] npc;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] exc, input logic [31:0] pc,
                       input logic ds, input logic [31:0] bad,
                       input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra,
                       input logic [31:0] npc, input logic [31:0] rd);
        vec_t v;
        v.exc = exc; v.pc = pc; v.ds = ds; v.bad = bad;
        v.we = we; v.wa = wa; v.wd = wd; v.ra = ra;
        v.npc = npc; v.rd = rd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle();
        excepttype_i = 32'h0; pc_i = 32'h0; in_delayslot_i = 1'b0;
        bad_addr_i = 32'h0; we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        tick();
        idle();
    endtask

    localparam logic [31:0] V = 32'hBFC00380;
    localparam logic [31:0] N = 32'h0;
`ifdef CP0_TIMER_EN
    localparam logic [31:0] CMP_RD = 32'h55;
`else
    localparam logic [31:0] CMP_RD = 32'h0;
`endif

    initial begin
        int fired_at;
        rst = 1'b1; int_i = 6'd0; raddr_i = 5'd0;
        idle();

        //   exc     pc           ds bad          we wa  wd           ra  npc          rd
        add(32'h0, 32'h0,       0, 32'h0,       1, 12, 32'hFFFFFFFF, 12, N,           32'h0040FF03);
        add(32'h0, 32'h0,       0, 32'h0,       1, 12, 32'h00000000, 12, N,           32'h00400000);
        add(32'h0, 32'h0,       0, 32'h0,       1, 14, 32'hDEADBEEF, 14, N,           32'hDEADBEEF);
        add(32'h0, 32'h0,       0, 32'h0,       1, 13, 32'hFFFFFFFF, 13, N,           32'h00000300);
        add(32'h0, 32'h0,       0, 32'h0,       1, 8,  32'h00001234, 8,  N,           32'h0);
        add(32'h4, 32'hBFC00100,0, 32'h3,       0, 0,  32'h0,        14, V,           32'hBFC00100);
        add(32'h0, 32'h0,       0, 32'h0,       0, 0,  32'h0,        8,  N,           32'h3);
        add(32'h0, 32'h0,       0, 32'h0,       0, 0,  32'h0,        13, N,           32'h00000310);
        add(32'h0, 32'h0,       0, 32'h0,       0, 0,  32'h0,        12, N,           32'h00400002);
        add(32'he, 32'h0,       0, 32'h0,       0, 0,  32'h0,        12, 32'hBFC00100,32'h00400000);
        add(32'h0, 32'h0,       0, 32'h0,       0, 0,  32'h0,        14, N,           32'hBFC00100);
        add(32'h8, 32'hBFC00204,1, 32'h0,       0, 0,  32'h0,        14, V,           32'hBFC00200);
        add(32'h0, 32'h0,       0, 32'h0,       0, 0,  32'h0,        13, N,           32'h80000320);
        add(32'h9, 32'h11111110,0, 32'h0,       0, 0,  32'h0,        14, V,           32'hBFC00200);
        add(32'h0, 32'h0,       0, 32'h0,       0, 0,  32'h0,        13, N,           32'h80000324);
        add(32'he, 32'h0,       0, 32'h0,       0, 0,  32'h0,        12, 32'hBFC00200,32'h00400000);
        add(32'hc, 32'h00400010,0, 32'h0,       1, 14, 32'h12345678, 14, V,           32'h00400010);
        add(32'h0, 32'h0,       0, 32'h0,       0, 0,  32'h0,        13, N,           32'h00000330);
        add(32'he, 32'h0,       0, 32'h0,       0, 0,  32'h0,        12, 32'h00400010,32'h00400000);
        add(32'h1, 32'h80000000,0, 32'h0,       0, 0,  32'h0,        13, V,           32'h00000300);
        add(32'he, 32'h0,       0, 32'h0,       0, 0,  32'h0,        15, 32'h80000000,32'h00004220);
        add(32'h5, 32'h00000100,0, 32'hCAFEF00D,0, 0,  32'h0,        8,  V,           32'hCAFEF00D);
        add(32'h0, 32'h0,       0, 32'h0,       0, 0,  32'h0,        13, N,           32'h00000314);
        add(32'he, 32'h0,       0, 32'h0,       1, 12, 32'hFFFFFFFF, 12, 32'h00000100,32'h00400000);
        add(32'h0, 32'h0,       0, 32'h0,       1, 11, 32'h00000055, 11, N,           CMP_RD);

        tick(); tick();
        raddr_i = 5'd12; #1 chk("rst_status", rdata_o, 32'h00400000);
        raddr_i = 5'd15; #1 chk("rst_prid", rdata_o, 32'h00004220);
        raddr_i = 5'd14; #1 chk("rst_epc", rdata_o, 32'h0);
        chk("rst_cause", cause_o, 32'h0);
        chk("rst_flush", {31'd0, flush_o}, 32'h0);
        chk("rst_newpc", newpc_o, 32'h0);
        chk("rst_tint", {31'd0, timer_int_o}, 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            excepttype_i = vecs[i].exc; pc_i = vecs[i].pc;
            in_delayslot_i = vecs[i].ds; bad_addr_i = vecs[i].bad;
            we_i = vecs[i].we; waddr_i = vecs[i].wa; wdata_i = vecs[i].wd;
            #1;
            chk($sformatf("v%0d_flush", i), {31'd0, flush_o},
                {31'd0, vecs[i].exc != 32'h0});
            chk($sformatf("v%0d_newpc", i), newpc_o, vecs[i].npc);
            tick();
            idle();
            raddr_i = vecs[i].ra;
            #1 chk($sformatf("v%0d_rdata", i), rdata_o, vecs[i].rd);
        end

        // Hardware interrupt lines land in Cause[15:10] one edge later
        int_i = 6'b100001;
        tick();
        chk("int_ip", cause_o & 32'h0000FC00, 32'h00008400);
        int_i = 6'd0;
        tick();
        chk("int_clr", cause_o & 32'h0000FC00, 32'h0);

`ifdef CP0_TIMER_EN
        mtc0(5'd11, 32'h4);
        mtc0(5'd9, 32'h0);
        fired_at = -1;
        for (int c = 0; c < 20 && fired_at < 0; c++) begin
            if (timer_int_o) fired_at = c;
            else tick();
        end
        checks++;
        if (fired_at < 6 || fired_at > 12) begin
            errors++;
            $display("FAIL timer_fire actual=%0d required=6..12", fired_at);
        end
        tick();
        chk("timer_ti", {31'd0, cause_o[30]}, 32'h1);
        chk("timer_ip7", {31'd0, cause_o[15]}, 32'h1);
        mtc0(5'd11, 32'h100);
        chk("timer_clr", {31'd0, timer_int_o}, 32'h0);
`else
        fired_at = 0;
        mtc0(5'd9, 32'h77);
        raddr_i = 5'd9; #1 chk("count_rd0", rdata_o, 32'h0);
        for (int c = 0; c < 10; c++) tick();
        chk("tint_off", {31'd0, timer_int_o}, 32'h0);
        chk("ti_off", {31'd0, cause_o[30]}, 32'h0);
`endif

        // Reset beats a simultaneous exception and MTC0
        excepttype_i = 32'h4; pc_i = 32'h40; bad_addr_i = 32'h99;
        we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'hFFFF;
        rst = 1'b1;
        tick();
        idle(); rst = 1'b0;
        chk("rstov_epc", epc_o, 32'h0);
        chk("rstov_status", status_o, 32'h00400000);
        chk("rstov_cause", cause_o, 32'h0);
        raddr_i = 5'd8; #1 chk("rstov_badv", rdata_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
